// File: rtl/tdc_multi_stop_core.sv
// Multi-stop TDC core: one START edge opens a window, and each STOP channel
// latches its first rising edge as a coarse tick count plus a fine delay-line
// code. Results are streamed out in channel order over valid/ready.
// Optional build macro: TDC_SEQ_TAG_EN appends an 8-bit measurement sequence
// number above the base result fields.
`timescale 1ns/1ps

module tdc_multi_stop_core #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned COARSE_W    = 29,
    parameter int unsigned FINE_W      = 5,
    parameter int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned RES_W      = CH_W + 1 + COARSE_W + FINE_W,
`ifdef TDC_SEQ_TAG_EN
    localparam int unsigned OUT_W      = RES_W + 8
`else
    localparam int unsigned OUT_W      = RES_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     cont,
    input  logic                     abort,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        stop,
    output logic [NUM_CH-1:0]        fine_sample,
    input  logic [NUM_CH*FINE_W-1:0] fine_code,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OUT_W-1:0]         res_data,
    output logic                     meas_done,
    output logic [2:0]               state_out
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StArmed = 3'd1;
    localparam logic [2:0] StMeas  = 3'd2;
    localparam logic [2:0] StLatch = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    localparam logic [COARSE_W-1:0] TimeoutVal = COARSE_W'(TIMEOUT_CYC);
    localparam logic [COARSE_W-1:0] CoarseMax  = {COARSE_W{1'b1}};
    localparam logic [CH_W-1:0]     LastIdx    = CH_W'(NUM_CH - 1);

    logic [2:0]          state_q, state_d;
    logic [COARSE_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NUM_CH-1:0]   flags_q, flags_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic                done_q, done_d;
    logic                start_d_q;
    logic [NUM_CH-1:0]   stop_d_q;
    logic [NUM_CH-1:0]   pend_q;
    logic [NUM_CH-1:0]   to_q;
    logic [NUM_CH-1:0]   cap;
    logic                timeout_hit;
    logic                start_rise;
    logic [NUM_CH-1:0]   stop_rise;

    logic [COARSE_W-1:0] coarse_q [NUM_CH];
    logic [FINE_W-1:0]   fine_q   [NUM_CH];

`ifdef TDC_SEQ_TAG_EN
    logic [7:0] seq_q;
`endif

    assign start_rise = start & ~start_d_q;
    assign stop_rise  = stop & ~stop_d_q;
    assign cnt_inc    = (cnt_q == CoarseMax) ? cnt_q : cnt_q + COARSE_W'(1);

    // Next-state, capture decode and drain sequencing; abort/rst override all.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        cap         = '0;
        timeout_hit = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d   = '0;
                flags_d = '0;
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                cnt_d   = '0;
                flags_d = '0;
                if (start_rise) state_d = StMeas;
            end
            StMeas: begin
                if (cnt_q == TimeoutVal) begin
                    timeout_hit = 1'b1;
                    state_d     = StLatch;
                end else begin
                    cap     = stop_rise & ~flags_q;
                    flags_d = flags_q | cap;
                    cnt_d   = cnt_inc;
                    if (&flags_d) state_d = StLatch;
                end
            end
            StLatch: begin
                // Gives a STOP on the last measuring cycle time to register its fine code.
                state_d = StDrain;
                idx_d   = '0;
            end
            StDrain: begin
                if (res_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = cont ? StArmed : StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort || rst) begin
            state_d     = StIdle;
            cnt_d       = '0;
            flags_d     = '0;
            idx_d       = '0;
            done_d      = 1'b0;
            cap         = '0;
            timeout_hit = 1'b0;
        end
    end

    // Control state, edge-detect history and timeout marks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            flags_q   <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            start_d_q <= 1'b0;
            stop_d_q  <= '0;
            pend_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            start_d_q <= start;
            stop_d_q  <= stop;
            pend_q    <= cap;
            if (state_q == StIdle || state_q == StArmed) begin
                to_q <= '0;
            end else if (timeout_hit) begin
                to_q <= ~flags_q;
            end
        end
    end

    // Per-channel result storage; fine code is taken one cycle after its sample strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                coarse_q[c] <= '0;
                fine_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cap[c]) coarse_q[c] <= cnt_inc;
                if (timeout_hit && !flags_q[c]) begin
                    coarse_q[c] <= TimeoutVal;
                    fine_q[c]   <= '0;
                end else if (pend_q[c]) begin
                    fine_q[c] <= fine_code[c*FINE_W +: FINE_W];
                end
            end
        end
    end

`ifdef TDC_SEQ_TAG_EN
    // Sequence tag advances only on completed measurements.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else if (done_d) begin
            seq_q <= seq_q + 8'd1;
        end
    end
`endif

    // Result word for the channel currently offered; zero when nothing is valid.
    always_comb begin
        res_data = '0;
        if (state_q == StDrain) begin
            res_data[RES_W-1:0] = {idx_q, to_q[idx_q], coarse_q[idx_q], fine_q[idx_q]};
`ifdef TDC_SEQ_TAG_EN
            res_data[OUT_W-1:RES_W] = seq_q;
`endif
        end
    end

    assign fine_sample = cap;
    assign res_valid   = (state_q == StDrain);
    assign meas_done   = done_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_tdc_multi_stop_core.sv
// Directed self-checking bench for tdc_multi_stop_core (default parameters).
`timescale 1ns/1ps

module tb_tdc_multi_stop_core;

`ifdef TDC_SEQ_TAG_EN
    localparam int OUT_W = 45;
`else
    localparam int OUT_W = 37;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             arm = 1'b0;
    logic             cont = 1'b0;
    logic             abort = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       stop = '0;
    logic [3:0]       fine_sample;
    logic [19:0]      fine_code = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [OUT_W-1:0] res_data;
    logic             meas_done;
    logic [2:0]       state_out;

    int          n_checks = 0;
    int          n_pass = 0;
    int          rel = 0;
    logic [36:0] exp_res [4];
    logic [7:0]  seq_exp = 8'd0;

    tdc_multi_stop_core dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .cont       (cont),
        .abort      (abort),
        .start      (start),
        .stop       (stop),
        .fine_sample(fine_sample),
        .fine_code  (fine_code),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .meas_done  (meas_done),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic advance_to(input int k);
        while (rel < k) step();
    endtask

    function automatic logic [36:0] mk(input int c, input bit to, input int coarse,
                                       input logic [4:0] f);
        logic [1:0]  cc;
        logic [28:0] co;
        cc = c[1:0];
        co = coarse[28:0];
        return {cc, to, co, f};
    endfunction

    function automatic logic [OUT_W-1:0] full(input int c);
`ifdef TDC_SEQ_TAG_EN
        return {seq_exp, exp_res[c]};
`else
        return exp_res[c];
`endif
    endfunction

    // arm pulse then START edge; rel counts edges after the START edge
    task automatic begin_meas();
        arm = 1'b1;
        step();
        arm = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        rel = 0;
    endtask

    // STOP edge on channel c sampled at edge 'off'; fine code valid only the cycle after
    task automatic stop_one(input int c, input int off, input logic [4:0] fv);
        advance_to(off - 1);
        stop[c] = 1'b1;
        fine_code[c*5 +: 5] = ~fv;
        #1;
        n_checks++;
        if (fine_sample !== (4'b0001 << c))
            $display("FAIL stop_ch%0d fine_sample: got %b want %b", c, fine_sample, 4'b0001 << c);
        else n_pass++;
        advance_to(off);
        stop[c] = 1'b0;
        fine_code[c*5 +: 5] = fv;
        advance_to(off + 1);
        fine_code[c*5 +: 5] = ~fv;
    endtask

    task automatic stop_all(input int off, input logic [19:0] good);
        advance_to(off - 1);
        stop = 4'hF;
        fine_code = ~good;
        #1;
        n_checks++;
        if (fine_sample !== 4'hF) $display("FAIL stop_all fine_sample: got %b want 1111", fine_sample);
        else n_pass++;
        advance_to(off);
        stop = 4'h0;
        fine_code = good;
        advance_to(off + 1);
        fine_code = ~good;
    endtask

    task automatic drain_check(input string name, input logic [2:0] exp_state);
        int guard;
        guard = 0;
        res_ready = 1'b1;
        while (res_valid !== 1'b1 && guard < 2000) begin
            step();
            guard++;
        end
        n_checks++;
        if (res_valid !== 1'b1) $display("FAIL %s valid: got %b want 1", name, res_valid);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== full(c))
                $display("FAIL %s ch%0d: got v=%b %h want %h", name, c, res_valid, res_data, full(c));
            else n_pass++;
            step();
        end
        n_checks++;
        if (meas_done !== 1'b1 || res_valid !== 1'b0 || state_out !== exp_state)
            $display("FAIL %s end: got done=%b v=%b st=%0d want done=1 v=0 st=%0d",
                     name, meas_done, res_valid, state_out, exp_state);
        else n_pass++;
        step();
        n_checks++;
        if (meas_done !== 1'b0) $display("FAIL %s done_pulse: got %b want 0", name, meas_done);
        else n_pass++;
        seq_exp++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (state_out !== 3'd0 || res_valid !== 1'b0 || meas_done !== 1'b0 ||
            fine_sample !== 4'h0 || res_data !== '0)
            $display("FAIL reset: got st=%0d v=%b d=%b fs=%b data=%h want all 0",
                     state_out, res_valid, meas_done, fine_sample, res_data);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (state_out !== 3'd0) $display("FAIL reset_idle: got %0d want 0", state_out);
        else n_pass++;
    endtask

    task automatic test_basic();
        res_ready = 1'b1;
        begin_meas();
        n_checks++;
        if (state_out !== 3'd2) $display("FAIL basic_meas_state: got %0d want 2", state_out);
        else n_pass++;
        stop_one(0, 10, 5'h0A);
        stop_one(1, 20, 5'h15);
        stop_one(2, 30, 5'h1F);
        stop_one(3, 40, 5'h01);
        exp_res[0] = mk(0, 1'b0, 10, 5'h0A);
        exp_res[1] = mk(1, 1'b0, 20, 5'h15);
        exp_res[2] = mk(2, 1'b0, 30, 5'h1F);
        exp_res[3] = mk(3, 1'b0, 40, 5'h01);
        drain_check("basic", 3'd0);
    endtask

    task automatic test_timeout();
        begin_meas();
        stop_one(2, 5, 5'h13);
        advance_to(1001);
        n_checks++;
        if (state_out !== 3'd3 || res_valid !== 1'b0)
            $display("FAIL timeout_latch: got st=%0d v=%b want st=3 v=0", state_out, res_valid);
        else n_pass++;
        exp_res[0] = mk(0, 1'b1, 1000, 5'h00);
        exp_res[1] = mk(1, 1'b1, 1000, 5'h00);
        exp_res[2] = mk(2, 1'b0, 5, 5'h13);
        exp_res[3] = mk(3, 1'b1, 1000, 5'h00);
        drain_check("timeout", 3'd0);
    endtask

    task automatic test_double_edge();
        arm = 1'b1;
        step();
        arm = 1'b0;
        start = 1'b1;
        stop[0] = 1'b1;
        #1;
        n_checks++;
        if (fine_sample !== 4'h0) $display("FAIL start_cycle_stop: got %b want 0000", fine_sample);
        else n_pass++;
        step();
        start = 1'b0;
        rel = 0;
        advance_to(6);
        stop[1] = 1'b1;
        stop[3] = 1'b1;
        fine_code[5 +: 5] = ~5'h07;
        fine_code[15 +: 5] = ~5'h1C;
        #1;
        n_checks++;
        if (fine_sample !== 4'b1010) $display("FAIL dbl_first: got %b want 1010", fine_sample);
        else n_pass++;
        advance_to(7);
        stop[1] = 1'b0;
        stop[3] = 1'b0;
        fine_code[5 +: 5] = 5'h07;
        fine_code[15 +: 5] = 5'h1C;
        advance_to(8);
        fine_code[5 +: 5] = ~5'h07;
        fine_code[15 +: 5] = ~5'h1C;
        stop[1] = 1'b1;
        #1;
        n_checks++;
        if (fine_sample !== 4'h0) $display("FAIL dbl_second_edge: got %b want 0000", fine_sample);
        else n_pass++;
        exp_res[0] = mk(0, 1'b1, 1000, 5'h00);
        exp_res[1] = mk(1, 1'b0, 7, 5'h07);
        exp_res[2] = mk(2, 1'b1, 1000, 5'h00);
        exp_res[3] = mk(3, 1'b0, 7, 5'h1C);
        drain_check("double_edge", 3'd0);
        stop = 4'h0;
        step();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        res_ready = 1'b0;
        begin_meas();
        stop_all(3, {5'h04, 5'h03, 5'h02, 5'h11});
        exp_res[0] = mk(0, 1'b0, 3, 5'h11);
        exp_res[1] = mk(1, 1'b0, 3, 5'h02);
        exp_res[2] = mk(2, 1'b0, 3, 5'h03);
        exp_res[3] = mk(3, 1'b0, 3, 5'h04);
        for (int i = 0; i < 50; i++) begin
            if (res_valid !== 1'b1 || res_data !== full(0) || meas_done !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad != 0) $display("FAIL backpressure_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        drain_check("backpressure", 3'd0);
    endtask

    task automatic test_continuous();
        cont = 1'b1;
        begin_meas();
        stop_all(2, {5'h0F, 5'h0E, 5'h0D, 5'h0C});
        exp_res[0] = mk(0, 1'b0, 2, 5'h0C);
        exp_res[1] = mk(1, 1'b0, 2, 5'h0D);
        exp_res[2] = mk(2, 1'b0, 2, 5'h0E);
        exp_res[3] = mk(3, 1'b0, 2, 5'h0F);
        drain_check("cont_first", 3'd1);
        cont = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        rel = 0;
        stop_all(4, {5'h18, 5'h17, 5'h16, 5'h15});
        exp_res[0] = mk(0, 1'b0, 4, 5'h15);
        exp_res[1] = mk(1, 1'b0, 4, 5'h16);
        exp_res[2] = mk(2, 1'b0, 4, 5'h17);
        exp_res[3] = mk(3, 1'b0, 4, 5'h18);
        drain_check("cont_second", 3'd0);
    endtask

    task automatic test_abort_reset();
        int bad;
        bad = 0;
        res_ready = 1'b0;
        begin_meas();
        stop_all(2, {5'h1A, 5'h1B, 5'h1C, 5'h1D});
        exp_res[2] = mk(2, 1'b0, 2, 5'h1B);
        res_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== full(2))
            $display("FAIL abort_pre: got v=%b %h want %h", res_valid, res_data, full(2));
        else n_pass++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || state_out !== 3'd0 || meas_done !== 1'b0)
            $display("FAIL abort: got v=%b st=%0d done=%b want 0 0 0", res_valid, state_out, meas_done);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b0 || meas_done !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_quiet: got %0d bad cycles want 0", bad);
        else n_pass++;
        // Aborted measurement leaves the sequence tag unchanged.
        begin_meas();
        stop_all(2, {5'h05, 5'h06, 5'h07, 5'h08});
        exp_res[0] = mk(0, 1'b0, 2, 5'h08);
        exp_res[1] = mk(1, 1'b0, 2, 5'h07);
        exp_res[2] = mk(2, 1'b0, 2, 5'h06);
        exp_res[3] = mk(3, 1'b0, 2, 5'h05);
        drain_check("after_abort", 3'd0);
        // Reset in the middle of a measurement.
        begin_meas();
        advance_to(1);
        stop[0] = 1'b1;
        #1;
        n_checks++;
        if (fine_sample !== 4'b0001) $display("FAIL rst_pre_sample: got %b want 0001", fine_sample);
        else n_pass++;
        advance_to(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (state_out !== 3'd0 || res_valid !== 1'b0 || meas_done !== 1'b0 ||
            fine_sample !== 4'h0 || res_data !== '0)
            $display("FAIL rst_mid: got st=%0d v=%b d=%b fs=%b data=%h want all 0",
                     state_out, res_valid, meas_done, fine_sample, res_data);
        else n_pass++;
        stop = 4'h0;
        seq_exp = 8'd0;
        step();
        begin_meas();
        stop_all(6, {5'h09, 5'h0B, 5'h10, 5'h12});
        exp_res[0] = mk(0, 1'b0, 6, 5'h12);
        exp_res[1] = mk(1, 1'b0, 6, 5'h10);
        exp_res[2] = mk(2, 1'b0, 6, 5'h0B);
        exp_res[3] = mk(3, 1'b0, 6, 5'h09);
        drain_check("after_rst", 3'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_double_edge();
        test_backpressure();
        test_continuous();
        test_abort_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
